// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: show-ahead FIFO that captures retired-instruction trace records
// from the writeback stage and hands them to a slower valid/ready consumer.
// Records that arrive while the buffer is full are dropped. Every drop is
// reported through a sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   debug_wb_*            trace record from the core (sampled on rising edges)
//   clear                 synchronous flush of contents and status
//   out_valid/out_ready   consumer handshake; out_* show the head record
//   count/full/empty      occupancy
//   overflow/drop_cnt     sticky loss flag, saturating count of dropped records
module wb_trace_fifo #(
   parameter int unsigned DEPTH       = 16,
   parameter bit          FILTER_NOWB = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     debug_wb_have_inst,
   input  logic [31:0]              debug_wb_pc,
   input  logic                     debug_wb_ena,
   input  logic [4:0]               debug_wb_reg,
   input  logic [31:0]              debug_wb_value,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic                     out_ena,
   output logic [4:0]               out_reg,
   output logic [31:0]              out_value,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] value;
   } rec_t;

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   drop_q, drop_d;

   logic push, pop, accept, drop, is_full;
   rec_t wr_rec, head;

   // Handshake decode; a full buffer still accepts when the head leaves this cycle.
   always_comb begin
      is_full = (count_q == CW'(DEPTH));
      push    = debug_wb_have_inst & (~FILTER_NOWB | debug_wb_ena);
      pop     = (count_q != '0) & out_ready;
      accept  = push & (~is_full | pop);
      drop    = push & ~accept;
      wr_rec  = '{pc: debug_wb_pc, ena: debug_wb_ena, rd: debug_wb_reg, value: debug_wb_value};
   end

   // Next-state for pointers, occupancy and loss status; clear wins over everything.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         drop_d  = '0;
      end else begin
         if (accept) wptr_d = wptr_q + AW'(1);
         if (pop)    rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(accept) - CW'(pop);
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (accept && !clear) mem_q[wptr_q] <= wr_rec;
   end

   // Show-ahead head, zeroed while nothing is held.
   always_comb begin
      head      = mem_q[rptr_q];
      out_valid = (count_q != '0);
      out_pc    = out_valid ? head.pc    : 32'd0;
      out_ena   = out_valid ? head.ena   : 1'b0;
      out_reg   = out_valid ? head.rd    : 5'd0;
      out_value = out_valid ? head.value : 32'd0;
      count     = count_q;
      full      = is_full;
      empty     = (count_q == '0);
      overflow  = ovf_q;
      drop_cnt  = drop_q;
   end

endmodule
